// File: rtl/ledg_share_ctrl.sv
// Shares the 8-bit green LED bar between four clients: round-robin grants on a
// prescaled tick, minimum hold time, blank gap between owners, idle bounce.
module ledg_share_ctrl #(
  parameter int PRESC_W    = 21,
  parameter int HOLD_TICKS = 8
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic [3:0]  iREQ,
  input  logic [31:0] iPAT,
  output logic [3:0]  oGNT,
  output logic        oBUSY,
  output logic        oTICK,
  output logic [7:0]  LED
);

  typedef enum logic [1:0] {IDLE, OWN, GAP} state_t;

  state_t             state, state_nxt;
  logic [PRESC_W-1:0] cnt;
  logic               tick;
  logic [7:0]         led, led_nxt;
  logic               dir, dir_nxt;
  logic [3:0]         gnt, gnt_nxt;
  logic [1:0]         last, last_nxt;
  logic [7:0]         hold, hold_nxt;
  logic               busy;

  logic [1:0]         winner;
  logic [1:0]         idx;
  logic               found;
  logic [7:0]         owner_pat;
  logic [7:0]         winner_pat;
  logic               others;

  assign tick  = &cnt;
  assign oTICK = tick;
  assign oGNT  = gnt;
  assign oBUSY = busy;
  assign LED   = led;

  // The previous owner is searched last, so it only wins when nobody else asks.
  always_comb begin
    found  = 1'b0;
    winner = last;
    idx    = last;
    for (int i = 1; i <= 4; i++) begin
      idx = last + 2'(i);
      if (!found && iREQ[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  assign owner_pat  = iPAT[{last, 3'b000} +: 8];
  assign winner_pat = iPAT[{winner, 3'b000} +: 8];
  assign others     = |(iREQ & ~gnt);

  always_comb begin
    state_nxt = state;
    led_nxt   = led;
    dir_nxt   = dir;
    gnt_nxt   = gnt;
    last_nxt  = last;
    hold_nxt  = hold;

    case (state)
      IDLE: begin
        if (tick) begin
          if (found) begin
            state_nxt = OWN;
            gnt_nxt   = 4'b0001 << winner;
            last_nxt  = winner;
            hold_nxt  = 8'(HOLD_TICKS - 1);
            led_nxt   = winner_pat;
          end else if (!dir) begin
            if (led == 8'h80) begin
              led_nxt = 8'h40;
              dir_nxt = 1'b1;
            end else begin
              led_nxt = led << 1;
            end
          end else begin
            if (led == 8'h01) begin
              led_nxt = 8'h02;
              dir_nxt = 1'b0;
            end else begin
              led_nxt = led >> 1;
            end
          end
        end
      end

      OWN: begin
        // Pattern follows the owner every clock, not just on ticks.
        led_nxt = owner_pat;
        if (tick) begin
          if (!iREQ[last]) begin
            state_nxt = GAP;
            gnt_nxt   = 4'b0000;
            led_nxt   = 8'h00;
          end else if (hold != 8'd0) begin
            hold_nxt = hold - 8'd1;
          end else if (others) begin
            state_nxt = GAP;
            gnt_nxt   = 4'b0000;
            led_nxt   = 8'h00;
          end
        end
      end

      GAP: begin
        if (tick) begin
          if (found) begin
            state_nxt = OWN;
            gnt_nxt   = 4'b0001 << winner;
            last_nxt  = winner;
            hold_nxt  = 8'(HOLD_TICKS - 1);
            led_nxt   = winner_pat;
          end else begin
            state_nxt = IDLE;
            led_nxt   = 8'h01;
            dir_nxt   = 1'b0;
          end
        end
      end

      default: begin
        state_nxt = IDLE;
        gnt_nxt   = 4'b0000;
        led_nxt   = 8'h01;
        dir_nxt   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      cnt   <= '0;
      state <= IDLE;
      led   <= 8'h01;
      dir   <= 1'b0;
      gnt   <= 4'b0000;
      last  <= 2'd3;
      hold  <= 8'd0;
      busy  <= 1'b0;
    end else begin
      cnt   <= cnt + PRESC_W'(1);
      state <= state_nxt;
      led   <= led_nxt;
      dir   <= dir_nxt;
      gnt   <= gnt_nxt;
      last  <= last_nxt;
      hold  <= hold_nxt;
      busy  <= (state_nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_ledg_share_ctrl.sv
// Scoreboard bench for ledg_share_ctrl: a behavioural model predicts each
// cycle's outputs, queues them, and they are compared after the clock edge.
module tb_ledg_share_ctrl;

  localparam int PRESC_W    = 2;
  localparam int HOLD_TICKS = 3;
  localparam int CNT_MAX    = (1 << PRESC_W) - 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = 4'b0000;
  logic [31:0] pat = 32'h0;
  logic [3:0]  gnt;
  logic        busy;
  logic        tick;
  logic [7:0]  led;

  ledg_share_ctrl #(.PRESC_W(PRESC_W), .HOLD_TICKS(HOLD_TICKS)) dut (
    .iCLK  (clk),
    .iRST_N(rst_n),
    .iREQ  (req),
    .iPAT  (pat),
    .oGNT  (gnt),
    .oBUSY (busy),
    .oTICK (tick),
    .LED   (led)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] led;
    logic [3:0] gnt;
    logic       busy;
    logic       tick;
  } exp_t;

  exp_t sb[$];
  int   testsRun = 0;
  int   testsFailed = 0;

  // Reference model state: the idle animation is a position in a 14-step table.
  logic [7:0] bounceTab [14] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
                                 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02};
  int         mCnt = 0;
  int         mState = 0;
  int         mPos = 0;
  int         mOwner = 0;
  int         mLast = 3;
  int         mHold = 0;
  logic [7:0] mLed = 8'h01;
  logic [3:0] mGnt = 4'b0000;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic modelGrant(input logic [3:0] r, input logic [31:0] p);
    for (int k = 1; k <= 4; k++) begin
      int c;
      c = (mLast + k) % 4;
      if (r[c]) begin
        mOwner = c;
        mLast  = c;
        mGnt   = 4'(1 << c);
        mHold  = HOLD_TICKS - 1;
        mLed   = p[8*c +: 8];
        mState = 1;
        break;
      end
    end
  endtask

  task automatic modelStep(input logic [3:0] r, input logic [31:0] p, input logic rn);
    bit t;
    if (!rn) begin
      mCnt = 0; mState = 0; mPos = 0; mLast = 3; mHold = 0;
      mLed = 8'h01; mGnt = 4'b0000;
      return;
    end
    t = (mCnt == CNT_MAX);
    mCnt = (mCnt + 1) % (CNT_MAX + 1);
    if (mState == 0) begin
      if (t) begin
        if (r != 4'b0000) modelGrant(r, p);
        else begin
          mPos = (mPos + 1) % 14;
          mLed = bounceTab[mPos];
        end
      end
    end else if (mState == 1) begin
      mLed = p[8*mOwner +: 8];
      if (t) begin
        if (!r[mOwner] || (mHold == 0 && (r & ~mGnt) != 4'b0000)) begin
          mState = 2; mGnt = 4'b0000; mLed = 8'h00;
        end else if (mHold > 0) mHold--;
      end
    end else begin
      if (t) begin
        if (r != 4'b0000) modelGrant(r, p);
        else begin
          mState = 0; mPos = 0; mLed = 8'h01;
        end
      end
    end
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic [31:0] p, input logic rn);
    exp_t e, got;
    @(negedge clk);
    req   = r;
    pat   = p;
    rst_n = rn;
    modelStep(r, p, rn);
    e.led  = mLed;
    e.gnt  = mGnt;
    e.busy = (mState != 0);
    e.tick = (mCnt == CNT_MAX);
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    got = '{led: led, gnt: gnt, busy: busy, tick: tick};
    checkOutput("led",  32'(got.led),  32'(e.led));
    checkOutput("gnt",  32'(got.gnt),  32'(e.gnt));
    checkOutput("busy", 32'(got.busy), 32'(e.busy));
    checkOutput("tick", 32'(got.tick), 32'(e.tick));
  endtask

  task automatic runCycles(input int n, input logic [3:0] r, input logic [31:0] p);
    for (int i = 0; i < n; i++) applyStimulus(r, p, 1'b1);
  endtask

  initial begin
    logic [3:0]  rr;
    logic [31:0] pp;

    // Reset, then a full idle bounce period and a bit more.
    applyStimulus(4'b0000, 32'h0, 1'b0);
    applyStimulus(4'b0000, 32'h0, 1'b0);
    runCycles(16 * 4, 4'b0000, 32'h0);

    // Single owner, pattern change mid-tick, then release.
    runCycles(6, 4'b0001, 32'h0000_00A5);
    runCycles(10, 4'b0001, 32'h0000_005A);
    runCycles(12, 4'b0000, 32'h0000_005A);

    // Two steady requesters alternate with a gap between.
    for (int i = 0; i < 48; i++) applyStimulus(4'b0011, $urandom, 1'b1);
    runCycles(12, 4'b0000, 32'h0);

    // Client 2 releases early inside its hold time.
    runCycles(8, 4'b0100, 32'h00C3_0000);
    runCycles(12, 4'b0000, 32'h00C3_0000);

    // All four requesting from reset.
    applyStimulus(4'b1111, 32'h44332211, 1'b0);
    runCycles(25 * 4, 4'b1111, 32'h44332211);

    // Reset while client 3 owns with an all-on pattern.
    runCycles(12, 4'b1000, 32'hFF00_0000);
    applyStimulus(4'b1000, 32'hFF00_0000, 1'b0);
    runCycles(8, 4'b1000, 32'hFF00_0000);

    // Random request/pattern traffic with occasional resets.
    rr = 4'b0000;
    for (int i = 0; i < 240; i++) begin
      if ($urandom_range(0, 5) == 0) rr = 4'($urandom);
      pp = $urandom;
      applyStimulus(rr, pp, ($urandom_range(0, 99) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
